// File: rtl/fifo_stream_reader.sv
// Reads a registered-output FIFO and re-presents its words on a valid/ready stream.
// A 2-entry buffer absorbs the one-cycle read latency so back-pressure never drops a word.
module fifo_stream_reader #(
  parameter int unsigned DATA_BUS_SIZE = 32,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     fifo_empt,
  input  logic [DATA_BUS_SIZE-1:0] fifo_data,
  output logic                     fifo_rd,
  output logic [DATA_BUS_SIZE-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_WIDTH-1:0]     words_cnt,
  output logic                     busy
);

  logic [DATA_BUS_SIZE-1:0] buf_q [2];
  logic                     head_q;
  logic                     tail_q;
  logic [1:0]               count_q;
  logic [1:0]               count_d;
  logic                     inflight_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic                     pop;

  // count_q + inflight_q never exceeds 2, and a pop needs count_q != 0, so 2 bits suffice.
  always_comb begin
    pop       = 1'b0;
    count_d   = count_q;
    fifo_rd   = 1'b0;
    out_valid = (count_q != 2'd0);
    out_data  = '0;
    pop       = out_valid && out_ready;
    count_d   = count_q + {1'b0, inflight_q} - {1'b0, pop};
    fifo_rd   = !rst && en && !fifo_empt && (count_d < 2'd2);
    if (out_valid) begin
      out_data = buf_q[head_q];
    end
  end

  assign words_cnt = cnt_q;
  assign busy      = (count_q != 2'd0) || inflight_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= fifo_rd;
      count_q    <= count_d;
      // The FIFO presents the word one cycle after the accepted read.
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule
